wallace_csa_pipe: RTL and testbench

WALLACE_CSA_PIPE -- requirements
Module: wallace_csa_pipe

---
 rtl/wallace_pkg.sv | 6 +
 rtl/wallace_csa_pipe_if.sv | 17 +
 rtl/csa3to2.sv | 11 +
 rtl/wallace_csa_pipe.sv | 68 ++++++
 tb/tb_wallace_csa_pipe.sv | 124 ++++++++++++
 5 files changed

// File: rtl/wallace_pkg.sv
// wallace_pkg: operand/product widths and KPG carry codes shared by the multiplier tree and the final adder.
package wallace_pkg;
    localparam int OPW = 12;
    localparam int PW  = 2 * OPW;
    typedef enum logic [1:0] {KILL = 2'b00, PROP = 2'b01, GEN = 2'b10} kpg_e;
endpackage

// File: rtl/wallace_csa_pipe_if.sv
// wallace_csa_pipe_if: operand-in / carry-save-out handshake bundle.
interface wallace_csa_pipe_if #(parameter int OPW = wallace_pkg::OPW);
    localparam int PW = 2 * OPW;
    logic          in_valid;
    logic          in_ready;
    logic [OPW-1:0] in_x;
    logic [OPW-1:0] in_y;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_a;
    logic [PW-1:0] out_b;
    logic [1:0]    out_kin;
    modport master (output in_valid, in_x, in_y, out_ready,
                    input  in_ready, out_valid, out_a, out_b, out_kin);
    modport slave  (input  in_valid, in_x, in_y, out_ready,
                    output in_ready, out_valid, out_a, out_b, out_kin);
endinterface

// File: rtl/csa3to2.sv
// csa3to2: bitwise full-adder row; carry leaves shifted left by one, top carry dropped.
module csa3to2 #(parameter int W = 24) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] s_o,
    output logic [W-1:0] c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = ((a_i & b_i) | (a_i & c_i) | (b_i & c_i)) << 1;
endmodule

// File: rtl/wallace_csa_pipe.sv
// wallace_csa_pipe: 3-stage Wallace multiplier tree producing a carry-save product pair.
module wallace_csa_pipe #(parameter int OPW = wallace_pkg::OPW) (
    input  logic               clk,
    input  logic               rst_n,
    wallace_csa_pipe_if.slave  bus
);
    import wallace_pkg::*;
    localparam int PW = 2 * OPW;
    logic v1_q, v2_q, v3_q, en1, en2, en3;
    logic [PW-1:0] pp_d [OPW];
    logic [PW-1:0] pp_q [OPW];
    logic [PW-1:0] l1 [8];
    logic [PW-1:0] l2 [6];
    logic [PW-1:0] s2_d [4];
    logic [PW-1:0] s2_q [4];
    logic [PW-1:0] l4 [3];
    logic [PW-1:0] s3_d [2];
    logic [PW-1:0] s3_q [2];
    // a stage may load when it is empty or its contents move on this cycle
    assign en3 = !v3_q || bus.out_ready;
    assign en2 = !v2_q || en3;
    assign en1 = !v1_q || en2;
    assign bus.in_ready  = en1;
    assign bus.out_valid = v3_q;
    assign bus.out_a     = s3_q[0];
    assign bus.out_b     = s3_q[1];
    assign bus.out_kin   = KILL;
    genvar i;
    generate
        for (i = 0; i < OPW; i++) begin : g_pp
            assign pp_d[i] = (PW'(bus.in_x) & {PW{bus.in_y[i]}}) << i;
        end
        for (i = 0; i < 4; i++) begin : g_l1
            csa3to2 #(.W(PW)) u_csa (.a_i(pp_q[3*i]), .b_i(pp_q[3*i+1]), .c_i(pp_q[3*i+2]),
                                     .s_o(l1[2*i]), .c_o(l1[2*i+1]));
        end
        for (i = 0; i < 2; i++) begin : g_l2
            csa3to2 #(.W(PW)) u_csa (.a_i(l1[3*i]), .b_i(l1[3*i+1]), .c_i(l1[3*i+2]),
                                     .s_o(l2[2*i]), .c_o(l2[2*i+1]));
        end
        for (i = 0; i < 2; i++) begin : g_l3
            csa3to2 #(.W(PW)) u_csa (.a_i(l2[3*i]), .b_i(l2[3*i+1]), .c_i(l2[3*i+2]),
                                     .s_o(s2_d[2*i]), .c_o(s2_d[2*i+1]));
        end
    endgenerate
    assign l2[4] = l1[6];
    assign l2[5] = l1[7];
    csa3to2 #(.W(PW)) u_l4 (.a_i(s2_q[0]), .b_i(s2_q[1]), .c_i(s2_q[2]), .s_o(l4[0]), .c_o(l4[1]));
    assign l4[2] = s2_q[3];
    csa3to2 #(.W(PW)) u_l5 (.a_i(l4[0]), .b_i(l4[1]), .c_i(l4[2]), .s_o(s3_d[0]), .c_o(s3_d[1]));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            pp_q <= '{default: '0};
            s2_q <= '{default: '0};
            s3_q <= '{default: '0};
        end else begin
            if (en1) v1_q <= bus.in_valid;
            if (en2) v2_q <= v1_q;
            if (en3) v3_q <= v2_q;
            if (en1 && bus.in_valid) pp_q <= pp_d;
            if (en2 && v1_q) s2_q <= s2_d;
            if (en3 && v2_q) s3_q <= s3_d;
        end
    end
endmodule

// File: tb/tb_wallace_csa_pipe.sv
// tb_wallace_csa_pipe: directed and scoreboarded checks of the carry-save multiplier pipeline.
module tb_wallace_csa_pipe;
    import wallace_pkg::*;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    wallace_csa_pipe_if #(.OPW(OPW)) bus();
    wallace_csa_pipe #(.OPW(OPW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int n_cmp = 0, n_bad = 0, n_out = 0, n_acc = 0, cyc = 0, first_out = 0, last_out = 0;
    logic [PW-1:0] exp_q [$];
    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic step(logic iv, logic [OPW-1:0] x, logic [OPW-1:0] y, logic [PW-1:0] e, logic ordy);
        logic [PW-1:0] s;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_x      = x;
        bus.in_y      = y;
        bus.out_ready = ordy;
        #1;
        cyc++;
        if (bus.out_valid && bus.out_ready) begin
            s = bus.out_a + bus.out_b;
            chk("kin", 64'(bus.out_kin), 64'(KILL));
            if (exp_q.size() == 0) chk("extra_out", 1, 0);
            else chk("sum", s, exp_q.pop_front());
            if (n_out == 0) first_out = cyc;
            last_out = cyc;
            n_out++;
        end
        if (iv && bus.in_ready) begin
            exp_q.push_back(e);
            n_acc++;
        end
    endtask
    task automatic idle(int n, logic ordy);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, ordy);
    endtask
    initial begin
        logic [OPW-1:0] x, y;
        logic [PW-1:0] a0, b0;
        int base, acc0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_a", bus.out_a, 0);
        chk("rst_out_b", bus.out_b, 0);
        chk("rst_kin", bus.out_kin, 0);
        @(negedge clk) rst_n = 1'b1;
        // full-scale operands, latency of three cycles
        step(1'b1, 12'hFFF, 12'hFFF, 24'hFFE001, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, '0, '0, '0, 1'b1);
            chk("lat_valid", bus.out_valid, i == 3);
        end
        chk("lat_count", n_out, 1);
        step(1'b1, 12'h000, 12'hABC, 24'h000000, 1'b1);
        step(1'b1, 12'h001, 12'h800, 24'h000800, 1'b1);
        idle(4, 1'b1);
        chk("small_count", n_out, 3);
        // 100 back-to-back pairs must stream out on consecutive cycles
        n_out = 0;
        for (int i = 0; i < 100; i++) begin
            x = OPW'($urandom); y = OPW'($urandom);
            step(1'b1, x, y, PW'(x) * PW'(y), 1'b1);
        end
        idle(4, 1'b1);
        chk("b2b_count", n_out, 100);
        chk("b2b_span", last_out - first_out, 99);
        // stall downstream with upstream pushing
        base = n_out; acc0 = n_acc;
        for (int i = 0; i < 6; i++) begin
            x = OPW'(12'h100 + i); y = OPW'(12'h010 + i);
            step(1'b1, x, y, PW'(x) * PW'(y), 1'b0);
            if (i == 3) begin a0 = bus.out_a; b0 = bus.out_b; end
        end
        chk("stall_acc", n_acc - acc0, 3);
        chk("stall_rdy", bus.in_ready, 0);
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_a", bus.out_a, a0);
        chk("stall_b", bus.out_b, b0);
        idle(5, 1'b1);
        chk("stall_out", n_out - base, 3);
        // reset with two results in flight
        step(1'b1, 12'h0AA, 12'h055, 24'h003872, 1'b1);
        step(1'b1, 12'h0F0, 12'h00F, 24'h000E10, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_ready", bus.in_ready, 1);
        chk("mid_rst_a", bus.out_a, 0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, '0, '0, 1'b1);
            chk("rst_stale", bus.out_valid, 0);
        end
        base = n_out;
        step(1'b1, 12'h123, 12'h456, 24'h04EDC2, 1'b1);
        idle(4, 1'b1);
        chk("post_rst_out", n_out - base, 1);
        // bubbles on the input, random backpressure on the output
        base = n_out; acc0 = n_acc;
        for (int i = 0; i < 60; i++) begin
            x = OPW'($urandom); y = OPW'($urandom);
            step(i % 2 == 0, x, y, PW'(x) * PW'(y), 1'($urandom_range(0, 1)));
        end
        idle(8, 1'b1);
        chk("bub_count", n_out - base, n_acc - acc0);
        chk("bub_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
